// File: rtl/approx_mult_pkg.sv
// Shared definitions for the tile-based approximate multiplier:
// mode encodings, nibble-count derivation and the per-tile approximation rule.
package approx_mult_pkg;

  localparam int NIB_BITS  = 4;
  localparam int TILE_BITS = 2 * NIB_BITS;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_HALF  = 2'b01;
  localparam logic [1:0] MODE_ALL   = 2'b10;

  // Number of 4-bit nibbles in an operand of width w.
  function automatic int nib_count(input int w);
    return w / NIB_BITS;
  endfunction

  // The reserved encoding behaves as exact and is reported as exact.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == MODE_HALF || mode == MODE_ALL) ? mode : MODE_EXACT;
  endfunction

  // Tile (i, j) is approximate in HALF mode when its A-nibble index sits in
  // the upper half of the operand, and always in ALL mode.
  function automatic logic tile_is_approx(input logic [1:0] mode, input int i, input int n);
    logic res;
    res = 1'b0;
    if (mode == MODE_ALL)
      res = 1'b1;
    else if (mode == MODE_HALF)
      res = (i >= n / 2);
    return res;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_tile.sv
// 4x4 nibble multiplier tile. When approx is set, the TRUNC low bits of the
// 8-bit product are cleared; TRUNC is fixed at elaboration.
module approx_tile4 #(
  parameter int TRUNC = 2
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       approx,
  output logic [7:0] p
);

  localparam logic [7:0] KEEP_MASK = 8'(8'hFF << TRUNC);

  logic [7:0] exact;

  // Exact nibble product, optionally truncated.
  always_comb begin
    exact = {4'b0000, a} * {4'b0000, b};
    p     = approx ? (exact & KEEP_MASK) : exact;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: pipelined W x W unsigned multiplier made of N*N 4x4 tiles,
// each exact or truncated per the transaction mode, tiles summed exactly.
// Stages: S1 operands+mode, S2 tile products, S3 summed result.
// Optional build macro APPROX_MULT_ERR_STATS_EN adds txn_cnt/err_sum
// counters fed by an exact product carried alongside the pipeline.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int TRUNC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_r,
  output logic [1:0]     out_mode
`ifdef APPROX_MULT_ERR_STATS_EN
  ,
  output logic [31:0]    txn_cnt,
  output logic [31:0]    err_sum
`endif
);

  localparam int N  = nib_count(W);
  localparam int NT = N * N;
  localparam int PW = 2 * W;

  logic s1_valid, s2_valid, s3_valid;
  logic s1_advance, s2_advance;
  logic s1_load, s2_load, s3_load;
  logic accept;

  logic [W-1:0]         s1_a, s1_b;
  logic [1:0]           s1_mode, s2_mode;
  logic [TILE_BITS-1:0] tile_p  [NT];
  logic [TILE_BITS-1:0] s2_prod [NT];
  logic [PW-1:0]        tile_sum;

  // Handshake chain: a stage loads whenever the stage after it is empty or
  // draining, so bubbles collapse and in_ready sees out_ready combinationally.
  always_comb begin
    s3_load    = s2_valid & (~s3_valid | out_ready);
    s2_advance = s3_load;
    s2_load    = s1_valid & (~s2_valid | s2_advance);
    s1_advance = s2_load;
    in_ready   = ~s1_valid | s1_advance;
    accept     = in_valid & in_ready;
    s1_load    = accept;
  end

  assign out_valid = s3_valid;

  // Stage valid flags; reset flushes every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_load)         s1_valid <= 1'b1;
      else if (s1_advance) s1_valid <= 1'b0;
      if (s2_load)         s2_valid <= 1'b1;
      else if (s2_advance) s2_valid <= 1'b0;
      if (s3_load)         s3_valid <= 1'b1;
      else if (out_ready)  s3_valid <= 1'b0;
    end
  end

  // S1 operand capture; data registers carry no reset.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_a    <= in_a;
      s1_b    <= in_b;
      s1_mode <= norm_mode(in_mode);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      approx_tile4 #(.TRUNC(TRUNC)) u_tile (
        .a      (s1_a[NIB_BITS*gi +: NIB_BITS]),
        .b      (s1_b[NIB_BITS*gj +: NIB_BITS]),
        .approx (tile_is_approx(s1_mode, gi, N)),
        .p      (tile_p[gi*N + gj])
      );
    end
  end

  // S2 captures every tile product along with the mode.
  always_ff @(posedge clk) begin
    if (s2_load) begin
      s2_prod <= tile_p;
      s2_mode <= s1_mode;
    end
  end

  // Exact weighted sum of the tile products; 2W bits cannot overflow.
  always_comb begin
    tile_sum = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        tile_sum = tile_sum + (PW'(s2_prod[i*N + j]) << (NIB_BITS * (i + j)));
      end
    end
  end

  // S3 result register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r    <= '0;
      out_mode <= MODE_EXACT;
    end else if (s3_load) begin
      out_r    <= tile_sum;
      out_mode <= s2_mode;
    end
  end

`ifdef APPROX_MULT_ERR_STATS_EN
  logic [PW-1:0] s2_exact, s3_exact;
  logic [PW-1:0] err_beat;
  logic [64:0]   err_total;
  logic          deliver;

  // Exact product travels beside the tile pipeline, one stage behind S1.
  always_ff @(posedge clk) begin
    if (s2_load) s2_exact <= PW'(s1_a) * PW'(s1_b);
    if (s3_load) s3_exact <= s2_exact;
  end

  // Truncation only lowers tiles, so the exact product never falls below out_r.
  always_comb begin
    deliver   = s3_valid & out_ready;
    err_beat  = s3_exact - out_r;
    err_total = 65'(err_sum) + 65'(err_beat);
  end

  // Per-delivery counters: wrapping beat count, saturating error sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
      err_sum <= '0;
    end else if (deliver) begin
      txn_cnt <= txn_cnt + 32'd1;
      err_sum <= (err_total > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : err_total[31:0];
    end
  end
`endif

endmodule
